// File: rtl/riscv_pkg.sv
// Shared RV32I core types and constants.
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] regaddr_t;
  typedef logic [XLEN-1:0]       word_t;

  localparam regaddr_t ZERO_REG = '0;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-load scoreboard: one busy bit per register, flush > set > clear.
// Pending exclusion of the register being written depends on REGFILE_BYPASS_EN.
module reg_scoreboard
  import riscv_pkg::*;
#(
  parameter int P_ADDR_W = REG_ADDR_W,
  parameter int P_DEPTH  = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_ld_issue_e,
  input  logic [P_ADDR_W-1:0] i_ld_rd_e,
  input  logic                i_we_w,
  input  logic [P_ADDR_W-1:0] i_rd_addr_w,
  input  logic                i_flush,
  input  logic [P_ADDR_W-1:0] i_rs1_addr,
  input  logic [P_ADDR_W-1:0] i_rs2_addr,
  output logic                o_pend1,
  output logic                o_pend2
);
  logic [P_DEPTH-1:0] r_busy;
  logic [P_DEPTH-1:0] w_busy_nxt;
  logic               w_clr;
  logic               w_set;

  assign w_clr = i_we_w && (i_rd_addr_w != P_ADDR_W'(ZERO_REG));
  assign w_set = i_ld_issue_e && (i_ld_rd_e != P_ADDR_W'(ZERO_REG));

  // Set is applied after clear so a newer load to the same register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_clr) w_busy_nxt[i_rd_addr_w] = 1'b0;
    if (w_set) w_busy_nxt[i_ld_rd_e] = 1'b1;
    if (i_flush) w_busy_nxt = '0;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_busy <= '0;
    else          r_busy <= w_busy_nxt;
  end

  always_comb begin
    o_pend1 = r_busy[i_rs1_addr] && (i_rs1_addr != P_ADDR_W'(ZERO_REG));
    o_pend2 = r_busy[i_rs2_addr] && (i_rs2_addr != P_ADDR_W'(ZERO_REG));
`ifdef REGFILE_BYPASS_EN
    // The bypass supplies the value being written, so it is not pending.
    if (w_clr && (i_rd_addr_w == i_rs1_addr)) o_pend1 = 1'b0;
    if (w_clr && (i_rd_addr_w == i_rs2_addr)) o_pend2 = 1'b0;
`endif
  end
endmodule

// File: rtl/reg_file.sv
// RV32I integer register file with two combinational read ports and load-use stall.
// Optional write-through bypass enabled by REGFILE_BYPASS_EN.
module reg_file
  import riscv_pkg::*;
#(
  parameter int P_WIDTH  = XLEN,
  parameter int P_ADDR_W = REG_ADDR_W,
  parameter int P_DEPTH  = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [P_ADDR_W-1:0] i_rs1_addr_d,
  input  logic [P_ADDR_W-1:0] i_rs2_addr_d,
  output logic [P_WIDTH-1:0]  o_rs1_data_d,
  output logic [P_WIDTH-1:0]  o_rs2_data_d,
  input  logic                i_we_w,
  input  logic [P_ADDR_W-1:0] i_rd_addr_w,
  input  logic [P_WIDTH-1:0]  i_result_w,
  input  logic                i_ld_issue_e,
  input  logic [P_ADDR_W-1:0] i_ld_rd_e,
  input  logic                i_flush,
  output logic                o_stall_d
);
  logic [P_WIDTH-1:0] r_regs [P_DEPTH];
  logic               w_wr_en;
  logic               w_pend1;
  logic               w_pend2;

  assign w_wr_en = i_we_w && (i_rd_addr_w != P_ADDR_W'(ZERO_REG));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < P_DEPTH; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[i_rd_addr_w] <= i_result_w;
    end
  end

  always_comb begin
    o_rs1_data_d = r_regs[i_rs1_addr_d];
    o_rs2_data_d = r_regs[i_rs2_addr_d];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_en && (i_rd_addr_w == i_rs1_addr_d)) o_rs1_data_d = i_result_w;
    if (w_wr_en && (i_rd_addr_w == i_rs2_addr_d)) o_rs2_data_d = i_result_w;
`endif
    if (i_rs1_addr_d == P_ADDR_W'(ZERO_REG)) o_rs1_data_d = '0;
    if (i_rs2_addr_d == P_ADDR_W'(ZERO_REG)) o_rs2_data_d = '0;
  end

  reg_scoreboard #(
    .P_ADDR_W (P_ADDR_W),
    .P_DEPTH  (P_DEPTH)
  ) u_scoreboard (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_ld_issue_e (i_ld_issue_e),
    .i_ld_rd_e    (i_ld_rd_e),
    .i_we_w       (i_we_w),
    .i_rd_addr_w  (i_rd_addr_w),
    .i_flush      (i_flush),
    .i_rs1_addr   (i_rs1_addr_d),
    .i_rs2_addr   (i_rs2_addr_d),
    .o_pend1      (w_pend1),
    .o_pend2      (w_pend2)
  );

  assign o_stall_d = w_pend1 | w_pend2;
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file against an array-based register/scoreboard model.
module tb_reg_file;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1, rs2, rd, ldrd;
  logic [31:0] d1, d2, res;
  logic        we, ld, flush, stall;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];

  always #5 clk = ~clk;

  reg_file dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rs1_addr_d (rs1),
    .i_rs2_addr_d (rs2),
    .o_rs1_data_d (d1),
    .o_rs2_data_d (d2),
    .i_we_w       (we),
    .i_rd_addr_w  (rd),
    .i_result_w   (res),
    .i_ld_issue_e (ld),
    .i_ld_rd_e    (ldrd),
    .i_flush      (flush),
    .o_stall_d    (stall)
  );

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && rd == a) return res;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_pend(input logic [4:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (we && rd == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    we = 0; rd = 0; res = 0; ld = 0; ldrd = 0; flush = 0;
  endtask

  // Advance one clock edge, folding the currently driven inputs into the model.
  task automatic tick();
    @(posedge clk);
    if (we && rd != 0) m_regs[rd] = res;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (we && rd != 0) m_busy[rd] = 1'b0;
      if (ld && ldrd != 0) m_busy[ldrd] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; idle(); rs1 = 1; rs2 = 31;
    model_clear();
    #12; rst_n = 1;
    @(posedge clk); #1;
    checks++; if (d1 !== 32'h0) begin failures++; $display("FAIL reset_rs1 got=%h exp=%h", d1, 32'h0); end
    checks++; if (d2 !== 32'h0) begin failures++; $display("FAIL reset_rs2 got=%h exp=%h", d2, 32'h0); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
  endtask

  task automatic test_write_read();
    idle(); we = 1; rd = 5; res = 32'hDEADBEEF; tick();
    idle(); rs1 = 5; #2;
    checks++; if (d1 !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_x5 got=%h exp=%h", d1, 32'hDEADBEEF); end
    we = 1; rd = 0; res = 32'h1234; rs2 = 0; #2;
    checks++; if (d2 !== 32'h0) begin failures++; $display("FAIL wr_x0_same got=%h exp=0", d2); end
    tick(); idle(); #2;
    checks++; if (d2 !== 32'h0) begin failures++; $display("FAIL wr_x0_after got=%h exp=0", d2); end
  endtask

  task automatic test_bypass();
    logic [31:0] e;
    idle(); we = 1; rd = 7; res = 32'h11111111; tick();
    idle(); we = 1; rd = 7; res = 32'hA5A5A5A5; rs1 = 7; rs2 = 7; #2;
`ifdef REGFILE_BYPASS_EN
    e = 32'hA5A5A5A5;
`else
    e = 32'h11111111;
`endif
    checks++; if (d1 !== e) begin failures++; $display("FAIL bypass_rs1 got=%h exp=%h", d1, e); end
    checks++; if (d2 !== e) begin failures++; $display("FAIL bypass_rs2 got=%h exp=%h", d2, e); end
    tick(); idle(); #2;
    checks++; if (d1 !== 32'hA5A5A5A5) begin failures++; $display("FAIL bypass_next got=%h exp=%h", d1, 32'hA5A5A5A5); end
  endtask

  task automatic test_load_use();
    logic e;
    idle(); rs1 = 0; rs2 = 0; ld = 1; ldrd = 3; tick();
    idle(); rs1 = 3; #2;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_pending got=%b exp=1", stall); end
    we = 1; rd = 3; res = 32'h0BADF00D; #2;
`ifdef REGFILE_BYPASS_EN
    e = 1'b0;
`else
    e = 1'b1;
`endif
    checks++; if (stall !== e) begin failures++; $display("FAIL lu_wb_cycle got=%b exp=%b", stall, e); end
    tick(); idle(); #2;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_after got=%b exp=0", stall); end
    checks++; if (d1 !== 32'h0BADF00D) begin failures++; $display("FAIL lu_data got=%h exp=%h", d1, 32'h0BADF00D); end
  endtask

  task automatic test_collision();
    idle(); rs1 = 0; rs2 = 0; ld = 1; ldrd = 9; tick();
    idle(); we = 1; rd = 9; res = 32'h99; ld = 1; ldrd = 9; tick();
    idle(); rs2 = 9; #2;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL collide_stall got=%b exp=1", stall); end
    tick(); #2;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL collide_hold got=%b exp=1", stall); end
  endtask

  task automatic test_flush();
    idle(); rs1 = 0; rs2 = 0; ld = 1; ldrd = 4; tick();
    ldrd = 6; tick();
    idle(); flush = 1; ld = 1; ldrd = 8; tick();
    idle(); rs1 = 4; rs2 = 6; #2;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_4_6 got=%b exp=0", stall); end
    rs1 = 8; rs2 = 9; #2;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_same_set got=%b exp=0", stall); end
  endtask

  task automatic test_reset_mid();
    idle(); we = 1; rd = 10; res = 32'hCAFE0001; ld = 1; ldrd = 11; tick();
    idle(); rs1 = 10; rs2 = 11; #1;
    rst_n = 0; model_clear(); #1;
    checks++; if (d1 !== 32'h0) begin failures++; $display("FAIL rstmid_data got=%h exp=0", d1); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rstmid_stall got=%b exp=0", stall); end
    #1; rst_n = 1;
    tick(); #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rstmid_after got=%b exp=0", stall); end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    logic        es;
    for (int n = 0; n < 400; n++) begin
      we    = ($urandom_range(0, 1) == 1);
      rd    = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      res   = $urandom;
      ld    = ($urandom_range(0, 2) == 0);
      ldrd  = 5'($urandom_range(0, 7));
      flush = ($urandom_range(0, 19) == 0);
      rs1   = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rs2   = 5'($urandom_range(0, 7));
      #2;
      e1 = exp_rd(rs1);
      e2 = exp_rd(rs2);
      es = exp_pend(rs1) | exp_pend(rs2);
      checks++; if (d1 !== e1) begin failures++; $display("FAIL rand_rs1 n=%0d a=%0d got=%h exp=%h", n, rs1, d1, e1); end
      checks++; if (d2 !== e2) begin failures++; $display("FAIL rand_rs2 n=%0d a=%0d got=%h exp=%h", n, rs2, d2, e2); end
      checks++; if (stall !== es) begin failures++; $display("FAIL rand_stall n=%0d got=%b exp=%b", n, stall, es); end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_load_use();
    test_collision();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
